fm_phase_accumulator: RTL and testbench
=======================================

Name: fm_phase_accumulator

Overview:
- Stage directly downstream of the FM adapter.
- Consumes the per-sample phase increment (carrier pinc plus scaled modulation) over AXI-Stream and integrates it into a wrapping phase accumulator.
- Emits a truncated, offset-adjusted phase word over AXI-Stream to the sine LUT / DDS compiler that drives the DAC path.
- Also reports an accumulator wrap counter for carrier-cycle monitoring.

Parameters:
- PINC_WIDTH, 32, width of phase increment, accumulator and phase_offset.
- PHASE_OUT_WIDTH, 14, width of emitted phase (top bits of accumulator); must be < PINC_WIDTH.
- WRAP_CNT_WIDTH, 16, width of wrap counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  1 = accumulate; 0 = hold accumulator
- sync_clear  in  1  single-cycle pulse; zeroes accumulator, wrap counter, dither state
- phase_offset  in  PINC_WIDTH  static phase offset added after accumulation
- S_AXIS_tdata  in  PINC_WIDTH  unsigned phase increment (modulo 2^PINC_WIDTH)
- S_AXIS_tvalid  in  1  increment valid
- S_AXIS_tready  out  1  block can accept increment
- M_AXIS_tdata  out  PHASE_OUT_WIDTH  phase word
- M_AXIS_tvalid  out  1  phase word valid
- M_AXIS_tready  in  1  downstream accepts phase word
- wrap_count  out  WRAP_CNT_WIDTH  number of accumulator carry-outs, modulo 2^WRAP_CNT_WIDTH

Behaviour:
- Reset (aresetn=0, async):
  - acc=0, M_AXIS_tdata=0, M_AXIS_tvalid=0, wrap_count=0.
  - S_AXIS_tready=1 once reset deasserts.
- Handshake:
  - S_AXIS_tready = !M_AXIS_tvalid || M_AXIS_tready (combinational, single output register, no bubble at full rate).
  - Input beat accepted when S_AXIS_tvalid && S_AXIS_tready.
  - Exactly one output beat per accepted input beat.
- Latency: 1 cycle. Accepted beat at edge N gives M_AXIS_tvalid=1 with its phase after edge N.
- Output hold: M_AXIS_tvalid stays 1 and M_AXIS_tdata stays stable until M_AXIS_tready=1. With no new beat, M_AXIS_tvalid clears on the accepting edge.
- Accumulation on accepted beat:
  - base = sync_clear ? 0 : acc.
  - acc_new = enable ? base + S_AXIS_tdata : base.
  - acc <= acc_new, unsigned, wraps modulo 2^PINC_WIDTH.
  - Carry-out of the add (enable=1 only) increments wrap_count, which wraps at all-ones to 0.
- Output word: M_AXIS_tdata <= (acc_new + phase_offset)[PINC_WIDTH-1 -: PHASE_OUT_WIDTH]. Offset wrap is not counted.
- sync_clear without accepted beat: acc<=0, wrap_count<=0, no output beat. Current output register is unaffected.
- sync_clear with accepted beat: clear first, then add. acc_new = S_AXIS_tdata; wrap_count <= 0, with no carry possible.
- enable=0: beats are still accepted and produce output. acc is held, so output repeats (acc + offset). wrap_count is held.
- phase_offset is sampled at each output update; changes take effect on the next beat.
- No internal state machine beyond the output-valid flag; the pipeline is valid-driven.

Optional Feature:
- Macro PHASE_DITHER_EN.
- Defined:
  - 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seed 32'h0000_0001.
  - Advances once per accepted beat; reloads seed on reset and on sync_clear.
  - Its low (PINC_WIDTH-PHASE_OUT_WIDTH) bits are added to (acc_new + phase_offset) before truncation, modulo 2^PINC_WIDTH.
  - acc itself is never dithered.
- Undefined: pure truncation; no LFSR logic is synthesised.

Decomposition:
- Package fm_phase_pkg:
  - LFSR_POLY = 32'h8020_0003, LFSR_SEED = 32'h0000_0001.
  - DROP_BITS function (PINC_WIDTH-PHASE_OUT_WIDTH).
  - phase_t/pinc_t typedefs parameterised via localparams.
- Sub-module phase_dither_lfsr (enable, load_seed, state out), instantiated only under PHASE_DITHER_EN.

Test Plan:
- Reset: hold aresetn=0 for 2 cycles with tvalid=1 -> M_AXIS_tvalid=0, M_AXIS_tdata=0, wrap_count=0; after release, S_AXIS_tready=1.
- Steady carrier: pinc=32'h4000_0000, offset=0, M_AXIS_tready=1, enable=1, 5 beats -> outputs 14'h1000, 14'h2000, 14'h3000, 14'h0000, 14'h1000; wrap_count=1 after 4th beat.
- Backpressure: hold M_AXIS_tready=0 for 3 cycles mid-stream -> S_AXIS_tready=0, M_AXIS_tdata stable, acc unchanged; on release, sequence resumes with no lost or duplicated beat.
- Offset: pinc=0, offset=32'h8000_0000 -> every output 14'h2000; change offset to 32'hC000_0000 -> next beat 14'h3000.
- Clear with beat: acc=32'h3000_0000, sync_clear=1 coincident with beat pinc=32'h0100_0000 -> output 14'h0040, wrap_count=0; next beat gives 14'h0080.
- Enable and dither: enable=0 after acc=32'h2000_0000 -> outputs repeat 14'h0800, wrap_count held. With PHASE_DITHER_EN, pinc=0, acc=0 -> outputs vary only within 14'h0000..14'h0001 and match the LFSR reference model.

Source files
------------

// File: rtl/fm_phase_pkg.sv
// Shared types, LFSR constants and helpers for the FM phase accumulator.
package fm_phase_pkg;

  localparam int PINC_W      = 32;
  localparam int PHASE_OUT_W = 14;
  localparam int WRAP_CNT_W  = 16;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  typedef logic [PINC_W-1:0]      pinc_t;
  typedef logic [PHASE_OUT_W-1:0] phase_t;

  // Number of accumulator LSBs discarded when forming the output phase word.
  function automatic int drop_bits(input int pinc_width, input int phase_out_width);
    return pinc_width - phase_out_width;
  endfunction

  // Right-shifting Galois step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/fm_phase_accumulator_lfsr.sv
// Dither source: 32-bit Galois LFSR, only instantiated when PHASE_DITHER_EN is defined.
module phase_dither_lfsr
  import fm_phase_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        load_seed,
  output logic [31:0] state
);

  logic [31:0] state_reg;
  logic [31:0] start_state;

  // A seed reload takes effect in the same cycle, so a clear coincident
  // with a beat dithers that beat with the seed itself.
  assign start_state = load_seed ? LFSR_SEED : state_reg;
  assign state       = start_state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= LFSR_SEED;
    end else if (enable) begin
      state_reg <= lfsr_next(start_state);
    end else if (load_seed) begin
      state_reg <= LFSR_SEED;
    end
  end

endmodule

// File: rtl/fm_phase_accumulator.sv
// Wrapping phase accumulator with AXI-Stream in/out and carry-out counter.
// Optional output dither enabled by defining PHASE_DITHER_EN.
module fm_phase_accumulator
  import fm_phase_pkg::*;
#(
  parameter int PINC_WIDTH      = PINC_W,
  parameter int PHASE_OUT_WIDTH = PHASE_OUT_W,
  parameter int WRAP_CNT_WIDTH  = WRAP_CNT_W
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
  input  logic                       sync_clear,
  input  logic [PINC_WIDTH-1:0]      phase_offset,
  input  logic [PINC_WIDTH-1:0]      S_AXIS_tdata,
  input  logic                       S_AXIS_tvalid,
  output logic                       S_AXIS_tready,
  output logic [PHASE_OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                       M_AXIS_tvalid,
  input  logic                       M_AXIS_tready,
  output logic [WRAP_CNT_WIDTH-1:0]  wrap_count
);

  localparam int DROP = drop_bits(PINC_WIDTH, PHASE_OUT_WIDTH);

  logic [PINC_WIDTH-1:0]      acc_reg;
  logic [PHASE_OUT_WIDTH-1:0] tdata_reg;
  logic                       tvalid_reg;
  logic [WRAP_CNT_WIDTH-1:0]  wrap_reg;

  logic                  beat;
  logic [PINC_WIDTH-1:0] base;
  logic [PINC_WIDTH:0]   sum_ext;
  logic [PINC_WIDTH-1:0] acc_next;
  logic                  carry;
  logic [PINC_WIDTH-1:0] dither_word;
  logic [PINC_WIDTH-1:0] phase_full;

  assign S_AXIS_tready = !tvalid_reg || M_AXIS_tready;
  assign beat          = S_AXIS_tvalid && S_AXIS_tready;
  assign M_AXIS_tdata  = tdata_reg;
  assign M_AXIS_tvalid = tvalid_reg;
  assign wrap_count    = wrap_reg;

  // Clear happens before the add, so a cleared beat can never carry out.
  always_comb begin
    base       = sync_clear ? '0 : acc_reg;
    sum_ext    = {1'b0, base} + {1'b0, S_AXIS_tdata};
    acc_next   = enable ? sum_ext[PINC_WIDTH-1:0] : base;
    carry      = enable && sum_ext[PINC_WIDTH];
    phase_full = acc_next + phase_offset + dither_word;
  end

`ifdef PHASE_DITHER_EN
  localparam logic [31:0] DITHER_MASK = (DROP >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << DROP) - 32'd1);
  logic [31:0] lfsr_state;

  phase_dither_lfsr u_lfsr (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .enable    (beat),
    .load_seed (sync_clear),
    .state     (lfsr_state)
  );

  assign dither_word = PINC_WIDTH'(lfsr_state & DITHER_MASK);
`else
  assign dither_word = '0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_reg    <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      wrap_reg   <= '0;
    end else if (beat) begin
      acc_reg    <= acc_next;
      tdata_reg  <= phase_full[PINC_WIDTH-1 -: PHASE_OUT_WIDTH];
      tvalid_reg <= 1'b1;
      wrap_reg   <= sync_clear ? '0 : wrap_reg + WRAP_CNT_WIDTH'(carry);
    end else begin
      if (sync_clear) begin
        acc_reg  <= '0;
        wrap_reg <= '0;
      end
      if (M_AXIS_tready) begin
        tvalid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fm_phase_accumulator.sv
// Randomised and directed bench for fm_phase_accumulator against an arithmetic reference model.
module tb_fm_phase_accumulator;

  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b1;
  logic        sync_clear = 1'b0;
  logic [31:0] phase_offset = '0;
  logic [31:0] S_AXIS_tdata = '0;
  logic        S_AXIS_tvalid = 1'b0;
  logic        S_AXIS_tready;
  logic [13:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready = 1'b1;
  logic [15:0] wrap_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_acc   = '0;
  logic [15:0] m_wrap  = '0;
  logic [13:0] m_out   = '0;
  bit          m_valid = 1'b0;
  logic [31:0] m_lfsr  = SEED;

  fm_phase_accumulator dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .sync_clear    (sync_clear),
    .phase_offset  (phase_offset),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .wrap_count    (wrap_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // move to just after the next rising edge.
  task automatic tick();
    bit              beat;
    longint unsigned sum;
    logic [31:0]     eff;
    logic [31:0]     dith;
    logic [31:0]     full;
    beat = S_AXIS_tvalid && (!m_valid || M_AXIS_tready);
    dith = '0;
    eff  = '0;
    if (beat) begin
      if (sync_clear) begin
        m_acc  = '0;
        m_wrap = '0;
      end
      if (enable) begin
        sum = longint'(m_acc) + longint'(S_AXIS_tdata);
        if (sum > 64'h0000_0000_FFFF_FFFF) m_wrap = m_wrap + 16'd1;
        m_acc = sum[31:0];
      end
`ifdef PHASE_DITHER_EN
      eff    = sync_clear ? SEED : m_lfsr;
      dith   = eff & 32'h0003_FFFF;
      m_lfsr = lfsr_step(eff);
`endif
      full    = m_acc + phase_offset + dith;
      m_out   = full[31:18];
      m_valid = 1'b1;
    end else begin
      if (sync_clear) begin
        m_acc  = '0;
        m_wrap = '0;
        m_lfsr = SEED;
      end
      if (M_AXIS_tready) m_valid = 1'b0;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn       = 1'b0;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'h1234_5678;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (M_AXIS_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tvalid: got %b expected 0", M_AXIS_tvalid);
    end
    checks++;
    if (M_AXIS_tdata !== 14'h0) begin
      errors++;
      $display("FAIL reset_tdata: got %h expected 0000", M_AXIS_tdata);
    end
    checks++;
    if (wrap_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_wrap: got %h expected 0000", wrap_count);
    end
    S_AXIS_tvalid = 1'b0;
    aresetn       = 1'b1;
    #1;
    checks++;
    if (S_AXIS_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b expected 1", S_AXIS_tready);
    end
    @(posedge aclk);
    #1;
    $display("reset: tvalid=%b tdata=%h wrap=%h", M_AXIS_tvalid, M_AXIS_tdata, wrap_count);
  endtask

  task automatic test_steady_carrier();
    logic [13:0] exp_tab [5];
    exp_tab = '{14'h1000, 14'h2000, 14'h3000, 14'h0000, 14'h1000};
    enable        = 1'b1;
    phase_offset  = '0;
    M_AXIS_tready = 1'b1;
    S_AXIS_tdata  = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      S_AXIS_tvalid = 1'b1;
      tick();
      checks++;
      if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== exp_tab[i]) begin
        errors++;
        $display("FAIL carrier_beat%0d: got v=%b d=%h expected v=1 d=%h",
                 i, M_AXIS_tvalid, M_AXIS_tdata, exp_tab[i]);
      end
      if (i == 3) begin
        checks++;
        if (wrap_count !== 16'd1) begin
          errors++;
          $display("FAIL carrier_wrap: got %0d expected 1", wrap_count);
        end
      end
      $display("carrier beat %0d: phase=%h wrap=%0d", i, M_AXIS_tdata, wrap_count);
    end
    S_AXIS_tvalid = 1'b0;
    tick();
    checks++;
    if (M_AXIS_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL carrier_drain: got tvalid=%b expected 0", M_AXIS_tvalid);
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] held;
    S_AXIS_tdata  = 32'h1000_0000;
    S_AXIS_tvalid = 1'b1;
    M_AXIS_tready = 1'b1;
    tick();
    held = M_AXIS_tdata;
    checks++;
    if (held !== 14'h1400) begin
      errors++;
      $display("FAIL bp_first: got %h expected 1400", held);
    end
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (S_AXIS_tready !== 1'b0) begin
        errors++;
        $display("FAIL bp_tready%0d: got %b expected 0", i, S_AXIS_tready);
      end
      tick();
      checks++;
      if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== held) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=%h",
                 i, M_AXIS_tvalid, M_AXIS_tdata, held);
      end
      $display("backpressure cycle %0d: phase=%h", i, M_AXIS_tdata);
    end
    M_AXIS_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (M_AXIS_tdata !== (i == 0 ? 14'h1800 : 14'h1C00) || M_AXIS_tdata !== m_out) begin
        errors++;
        $display("FAIL bp_resume%0d: got %h expected %h", i, M_AXIS_tdata, m_out);
      end
      $display("backpressure resume %0d: phase=%h", i, M_AXIS_tdata);
    end
    S_AXIS_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_offset();
    sync_clear = 1'b1;
    tick();
    sync_clear = 1'b0;
    checks++;
    if (wrap_count !== 16'd0 || M_AXIS_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: got wrap=%0d v=%b expected wrap=0 v=0", wrap_count, M_AXIS_tvalid);
    end
    S_AXIS_tdata  = '0;
    S_AXIS_tvalid = 1'b1;
    phase_offset  = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) phase_offset = 32'hC000_0000;
      tick();
      checks++;
      if (M_AXIS_tdata !== (i == 3 ? 14'h3000 : 14'h2000)) begin
        errors++;
        $display("FAIL offset%0d: got %h expected %h", i, M_AXIS_tdata, (i == 3 ? 14'h3000 : 14'h2000));
      end
      $display("offset beat %0d: offset=%h phase=%h", i, phase_offset, M_AXIS_tdata);
    end
    phase_offset = '0;
  endtask

  task automatic test_clear_with_beat();
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'hF000_0000;
    tick();
    S_AXIS_tdata  = 32'h4000_0000;
    tick();
    checks++;
    if (M_AXIS_tdata !== 14'h0C00 || wrap_count !== 16'd1) begin
      errors++;
      $display("FAIL pre_clear: got d=%h wrap=%0d expected d=0c00 wrap=1", M_AXIS_tdata, wrap_count);
    end
    sync_clear   = 1'b1;
    S_AXIS_tdata = 32'h0100_0000;
    tick();
    sync_clear = 1'b0;
    checks++;
    if (M_AXIS_tdata !== 14'h0040 || wrap_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_beat: got d=%h wrap=%0d expected d=0040 wrap=0", M_AXIS_tdata, wrap_count);
    end
    $display("clear with beat: phase=%h wrap=%0d", M_AXIS_tdata, wrap_count);
    tick();
    checks++;
    if (M_AXIS_tdata !== 14'h0080) begin
      errors++;
      $display("FAIL after_clear: got %h expected 0080", M_AXIS_tdata);
    end
    $display("after clear: phase=%h", M_AXIS_tdata);
  endtask

  task automatic test_enable_hold();
    logic [15:0] wrap_before;
    S_AXIS_tdata = 32'h1E00_0000;
    tick();
    wrap_before = m_wrap;
    enable      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S_AXIS_tdata = $urandom;
      tick();
      checks++;
      if (M_AXIS_tdata !== 14'h0800 || wrap_count !== wrap_before) begin
        errors++;
        $display("FAIL enable_hold%0d: got d=%h wrap=%0d expected d=0800 wrap=%0d",
                 i, M_AXIS_tdata, wrap_count, wrap_before);
      end
      $display("enable=0 beat %0d: phase=%h wrap=%0d", i, M_AXIS_tdata, wrap_count);
    end
    enable        = 1'b1;
    S_AXIS_tvalid = 1'b0;
    tick();
  endtask

`ifdef PHASE_DITHER_EN
  task automatic test_dither();
    S_AXIS_tvalid = 1'b1;
    sync_clear    = 1'b1;
    S_AXIS_tdata  = 32'h0003_F000;
    tick();
    sync_clear   = 1'b0;
    S_AXIS_tdata = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (M_AXIS_tdata !== m_out || M_AXIS_tdata > 14'h0001) begin
        errors++;
        $display("FAIL dither%0d: got %h expected %h", i, M_AXIS_tdata, m_out);
      end
      $display("dither beat %0d: phase=%h", i, M_AXIS_tdata);
    end
    S_AXIS_tvalid = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      S_AXIS_tvalid = ($urandom_range(0, 3) != 0);
      M_AXIS_tready = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      sync_clear    = ($urandom_range(0, 31) == 0);
      S_AXIS_tdata  = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 32'h0FFF_FFFF);
      if ($urandom_range(0, 15) == 0) phase_offset = $urandom;
      #1;
      checks++;
      if (S_AXIS_tready !== (!m_valid || M_AXIS_tready)) begin
        errors++;
        $display("FAIL rand_tready%0d: got %b expected %b", i, S_AXIS_tready, (!m_valid || M_AXIS_tready));
      end
      tick();
      checks++;
      if (M_AXIS_tvalid !== m_valid || (m_valid && M_AXIS_tdata !== m_out) || wrap_count !== m_wrap) begin
        errors++;
        $display("FAIL rand%0d: got v=%b d=%h w=%h expected v=%b d=%h w=%h",
                 i, M_AXIS_tvalid, M_AXIS_tdata, wrap_count, m_valid, m_out, m_wrap);
      end
      $display("random %0d: v=%b phase=%h wrap=%0d", i, M_AXIS_tvalid, M_AXIS_tdata, wrap_count);
    end
    S_AXIS_tvalid = 1'b0;
    sync_clear    = 1'b0;
    enable        = 1'b1;
    M_AXIS_tready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_steady_carrier();
    test_backpressure();
    test_offset();
    test_clear_with_beat();
    test_enable_hold();
`ifdef PHASE_DITHER_EN
    test_dither();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
